// File: rtl/execute_stage_p.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | execute_stage_p : MIPS execute stage with forwarding, iterative mul,  |
// |                   flush and a registered, valid-tagged EX/MEM stage.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module execute_stage_p #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             flush,
  input  logic [1:0]       wb_ctl,
  input  logic [2:0]       m_ctl,
  input  logic             regdst,
  input  logic             alusrc,
  input  logic [1:0]       aluop,
  input  logic [WIDTH-1:0] npc,
  input  logic [WIDTH-1:0] rdata1,
  input  logic [WIDTH-1:0] rdata2,
  input  logic [WIDTH-1:0] imm,
  input  logic [REGW-1:0]  rs,
  input  logic [REGW-1:0]  rt,
  input  logic [REGW-1:0]  rd,
  input  logic             mem_regwrite,
  input  logic             wb_regwrite,
  input  logic [REGW-1:0]  mem_rd,
  input  logic [REGW-1:0]  wb_rd,
  input  logic [WIDTH-1:0] mem_result,
  input  logic [WIDTH-1:0] wb_result,
  output logic             ex_stall,
  output logic             ex_mem_valid,
  output logic [1:0]       wb_ctlout,
  output logic             branch,
  output logic             memread,
  output logic             memwrite,
  output logic [WIDTH-1:0] br_target,
  output logic             zero,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] rdata2out,
  output logic [REGW-1:0]  dest_reg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH-1:0] fwd_a, fwd_b, opb, alu_res, res_sel;
  logic [5:0]       funct;
  logic             is_mul, stall_w, valid_d;

  // MEM stage is younger than WB, so it wins when both match
  always_comb begin
    fwd_a = rdata1;
    if (mem_regwrite && (mem_rd == rs) && (rs != '0))     fwd_a = mem_result;
    else if (wb_regwrite && (wb_rd == rs) && (rs != '0))  fwd_a = wb_result;
    fwd_b = rdata2;
    if (mem_regwrite && (mem_rd == rt) && (rt != '0))     fwd_b = mem_result;
    else if (wb_regwrite && (wb_rd == rt) && (rt != '0))  fwd_b = wb_result;
  end

  assign funct = imm[5:0];
  assign opb   = alusrc ? imm : fwd_b;

  always_comb begin
    is_mul  = 1'b0;
    alu_res = fwd_a + opb;
    case (aluop)
      2'b01: alu_res = fwd_a - opb;
      2'b11: alu_res = fwd_a | opb;
      2'b10: begin
        case (funct)
          6'b100010: alu_res = fwd_a - opb;
          6'b100100: alu_res = fwd_a & opb;
          6'b100101: alu_res = fwd_a | opb;
          6'b101010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(opb))};
          6'b011000: is_mul  = 1'b1;
          default:   alu_res = fwd_a + opb;
        endcase
      end
      default: alu_res = fwd_a + opb;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    stall_w  = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (id_valid && is_mul) begin
            state_d  = S_BUSY;
            cnt_d    = '0;
            mcand_d  = fwd_a;
            mplier_d = opb;
            prod_d   = '0;
            stall_w  = 1'b1;
          end
        end
        S_BUSY: begin
          stall_w  = 1'b1;
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Combinational stall must also read low while reset is held
  assign ex_stall = stall_w & rst_n;

  always_comb begin
    valid_d = 1'b0;
    res_sel = alu_res;
    if (!flush) begin
      if (state_q == S_DONE) begin
        valid_d = 1'b1;
        res_sel = prod_q;
      end else if ((state_q == S_IDLE) && id_valid && !is_mul) begin
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      prod_q       <= '0;
      ex_mem_valid <= 1'b0;
      wb_ctlout    <= '0;
      branch       <= 1'b0;
      memread      <= 1'b0;
      memwrite     <= 1'b0;
      br_target    <= '0;
      zero         <= 1'b0;
      alu_result   <= '0;
      rdata2out    <= '0;
      dest_reg     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      prod_q       <= prod_d;
      ex_mem_valid <= valid_d;
      wb_ctlout    <= valid_d ? wb_ctl : 2'b00;
      branch       <= valid_d & m_ctl[2];
      memread      <= valid_d & m_ctl[1];
      memwrite     <= valid_d & m_ctl[0];
      br_target    <= npc + (imm << 2);
      zero         <= (res_sel == '0);
      alu_result   <= res_sel;
      rdata2out    <= fwd_b;
      dest_reg     <= regdst ? rd : rt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage_p.sv
`default_nettype none
// Directed self-checking bench for execute_stage_p at WIDTH=8.
module tb_execute_stage_p;

  localparam int WIDTH = 8;
  localparam int REGW  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid, flush, regdst, alusrc;
  logic [1:0]       wb_ctl, aluop;
  logic [2:0]       m_ctl;
  logic [WIDTH-1:0] npc, rdata1, rdata2, imm, mem_result, wb_result;
  logic [REGW-1:0]  rs, rt, rd, mem_rd, wb_rd;
  logic             mem_regwrite, wb_regwrite;
  logic             ex_stall, ex_mem_valid, branch, memread, memwrite, zero;
  logic [1:0]       wb_ctlout;
  logic [WIDTH-1:0] br_target, alu_result, rdata2out;
  logic [REGW-1:0]  dest_reg;

  int cmp_cnt = 0;
  int err_cnt = 0;

  execute_stage_p #(.WIDTH(WIDTH), .REGW(REGW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .flush(flush),
    .wb_ctl(wb_ctl), .m_ctl(m_ctl), .regdst(regdst), .alusrc(alusrc),
    .aluop(aluop), .npc(npc), .rdata1(rdata1), .rdata2(rdata2), .imm(imm),
    .rs(rs), .rt(rt), .rd(rd), .mem_regwrite(mem_regwrite),
    .wb_regwrite(wb_regwrite), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_result(mem_result), .wb_result(wb_result), .ex_stall(ex_stall),
    .ex_mem_valid(ex_mem_valid), .wb_ctlout(wb_ctlout), .branch(branch),
    .memread(memread), .memwrite(memwrite), .br_target(br_target),
    .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
    .dest_reg(dest_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_valid = 0; flush = 0; wb_ctl = 0; m_ctl = 0; regdst = 0; alusrc = 0;
    aluop = 0; npc = 0; rdata1 = 0; rdata2 = 0; imm = 0; rs = 0; rt = 0; rd = 0;
    mem_regwrite = 0; wb_regwrite = 0; mem_rd = 0; wb_rd = 0;
    mem_result = 0; wb_result = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rtype(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b);
    clr();
    id_valid = 1; aluop = 2'b10; imm = {2'b00, f}; rdata1 = a; rdata2 = b;
    regdst = 1; rs = 5'd1; rt = 5'd2; rd = 5'd3; wb_ctl = 2'b11;
  endtask

  task automatic mul_run(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_p, input logic [4:0] dst);
    int n;
    rtype(6'b011000, a, b);
    rd = dst;
    #1;
    chk("mul_stall_T", ex_stall, 1);
    n = 0;
    while (ex_stall && n < 40) begin
      n++;
      tick();
      chk("mul_bubble", ex_mem_valid, 0);
    end
    chk("mul_stall_cycles", n, 9);
    tick();
    chk("mul_valid", ex_mem_valid, 1);
    chk("mul_result", alu_result, exp_p);
    chk("mul_dest", dest_reg, dst);
    chk("mul_wbctl", wb_ctlout, 2'b11);
    clr();
  endtask

  initial begin
    // reset with random inputs
    rst_n = 0;
    clr();
    id_valid = 1'($urandom); flush = 1'($urandom); wb_ctl = 2'($urandom);
    m_ctl = 3'($urandom); aluop = 2'b10; imm = 8'h18; rdata1 = 8'($urandom);
    rdata2 = 8'($urandom); npc = 8'($urandom); rs = 5'($urandom); rt = 5'($urandom);
    rd = 5'($urandom); regdst = 1'($urandom); id_valid = 1;
    tick(); tick();
    chk("rst_valid", ex_mem_valid, 0);
    chk("rst_wbctl", wb_ctlout, 0);
    chk("rst_mctl", {branch, memread, memwrite}, 0);
    chk("rst_brt", br_target, 0);
    chk("rst_zero", zero, 0);
    chk("rst_alu", alu_result, 0);
    chk("rst_rd2", rdata2out, 0);
    chk("rst_dest", dest_reg, 0);
    chk("rst_stall", ex_stall, 0);
    @(negedge clk);
    clr();
    rst_n = 1;
    tick();
    chk("post_rst_valid", ex_mem_valid, 0);

    // R-type add then sub
    rtype(6'b100000, 8'd5, 8'd7);
    tick();
    chk("add_res", alu_result, 12);
    chk("add_dest", dest_reg, 3);
    chk("add_zero", zero, 0);
    chk("add_valid", ex_mem_valid, 1);
    chk("add_wbctl", wb_ctlout, 2'b11);
    rtype(6'b100010, 8'd7, 8'd7);
    tick();
    chk("sub_res", alu_result, 0);
    chk("sub_zero", zero, 1);

    // and / slt / unknown funct
    rtype(6'b100100, 8'hF0, 8'h3C);
    tick();
    chk("and_res", alu_result, 8'h30);
    rtype(6'b101010, 8'hFE, 8'h03);
    tick();
    chk("slt_res", alu_result, 1);
    rtype(6'b111111, 8'h10, 8'h05);
    tick();
    chk("dflt_add", alu_result, 8'h15);

    // forwarding: MEM wins over WB
    rtype(6'b100000, 8'd9, 8'd1);
    rs = 5'd4; rt = 5'd4;
    mem_regwrite = 1; mem_rd = 5'd4; mem_result = 8'd100;
    wb_regwrite = 1; wb_rd = 5'd4; wb_result = 8'd50;
    tick();
    chk("fwd_mem_res", alu_result, 8'd200);
    chk("fwd_mem_rd2", rdata2out, 8'd100);
    mem_regwrite = 0;
    tick();
    chk("fwd_wb_res", alu_result, 8'd100);
    chk("fwd_wb_rd2", rdata2out, 8'd50);
    rs = 0; rt = 0; mem_regwrite = 1; mem_rd = 0; wb_rd = 0;
    tick();
    chk("fwd_r0_res", alu_result, 8'd10);
    chk("fwd_r0_rd2", rdata2out, 8'd1);

    // branch
    clr();
    id_valid = 1; aluop = 2'b01; npc = 8'h40; imm = 8'h03; m_ctl = 3'b100;
    rdata1 = 8'd6; rdata2 = 8'd6; rt = 5'd7;
    tick();
    chk("br_target", br_target, 8'h4C);
    chk("br_branch", branch, 1);
    chk("br_zero", zero, 1);
    chk("br_dest", dest_reg, 7);

    // or with immediate
    clr();
    id_valid = 1; aluop = 2'b11; alusrc = 1; rdata1 = 8'h50; imm = 8'h0F;
    m_ctl = 3'b011;
    tick();
    chk("ori_res", alu_result, 8'h5F);
    chk("ori_mctl", {branch, memread, memwrite}, 3'b011);

    // bubble
    clr();
    wb_ctl = 2'b11; m_ctl = 3'b111;
    tick();
    chk("bub_valid", ex_mem_valid, 0);
    chk("bub_ctl", {wb_ctlout, branch, memread, memwrite}, 0);

    // multiplies
    mul_run(8'd13, 8'd11, 8'h8F, 5'd9);
    mul_run(8'd20, 8'd20, 8'h90, 5'd12);

    // flush during BUSY
    rtype(6'b011000, 8'd3, 8'd5);
    tick(); tick(); tick(); tick();
    chk("fl_busy_stall", ex_stall, 1);
    flush = 1;
    #1;
    chk("fl_stall_drop", ex_stall, 0);
    tick();
    chk("fl_valid", ex_mem_valid, 0);
    rtype(6'b100000, 8'd2, 8'd3);
    #1;
    chk("fl_add_nostall", ex_stall, 0);
    tick();
    chk("fl_add_valid", ex_mem_valid, 1);
    chk("fl_add_res", alu_result, 5);

    // reset mid-multiply
    rtype(6'b011000, 8'd7, 8'd7);
    tick(); tick(); tick();
    rst_n = 0;
    #1;
    chk("mrst_stall", ex_stall, 0);
    chk("mrst_valid", ex_mem_valid, 0);
    clr();
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("mrst_after_valid", ex_mem_valid, 0);
    chk("mrst_after_stall", ex_stall, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
